simple_spi_master: RTL and testbench

SPI Mode 0 master (CPOL=0, CPHA=0) that drives SCLK, CS_N and MOSI and samples MISO. It takes a byte stream on a valid/ready handshake, holds CS_N low across consecutive bytes until a byte tagged "last" finishes, and returns each received byte as a single-cycle pulse. It is the initiator counterpart of `simple_spi_slave` and is used on-board to drive external SPI slaves and to exercise the slave in loopback.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_sync2.sv | 22 ++
 rtl/simple_spi_master.sv | 183 ++++++++++++++++++
 tb/tb_simple_spi_master.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, frame width and divider limits.
package spi_pkg;

   localparam int unsigned SPI_BITS    = 8;
   localparam int unsigned CLK_DIV_MIN = 4;
   localparam int unsigned CLK_DIV_MAX = 255;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_HIGH,
      ST_LOW,
      ST_BYTE_END,
      ST_WAIT,
      ST_HOLD,
      ST_GAP
   } state_t;

endpackage

// File: rtl/spi_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit SPI input.
module spi_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Two back-to-back flops; reset clears both stages.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/simple_spi_master.sv
// SPI mode 0 master: byte stream in on valid/ready, CS_N held low across a
// frame until a byte tagged last completes, received bytes out as pulses.
module simple_spi_master
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] i_tx_byte,
   input  logic       i_tx_last,
   input  logic       i_tx_valid,
   output logic       o_tx_ready,
   output logic [7:0] o_rx_byte,
   output logic       o_rx_valid,
   output logic       o_busy,
   output logic       o_spi_clk,
   output logic       o_spi_cs_n,
   output logic       o_spi_mosi,
   input  logic       i_spi_miso
);

   // Out-of-range dividers are clamped into the supported window.
   localparam int unsigned DIV = (CLK_DIV < CLK_DIV_MIN) ? CLK_DIV_MIN :
                                 (CLK_DIV > CLK_DIV_MAX) ? CLK_DIV_MAX : CLK_DIV;
   localparam logic [7:0] PHASE_END = 8'(DIV - 1);
   localparam logic [3:0] BITS_DONE = 4'(SPI_BITS);

   state_t              state, state_nx;
   logic [7:0]          phase_cnt, phase_cnt_nx;
   logic [3:0]          bit_cnt, bit_cnt_nx;
   logic [SPI_BITS-1:0] tx_sr, tx_sr_nx;
   logic [SPI_BITS-1:0] rx_sr, rx_sr_nx;
   logic                last_q, last_nx;
   logic                sclk, sclk_nx;
   logic                cs_n, cs_n_nx;
   logic                mosi, mosi_nx;
   logic [SPI_BITS-1:0] rx_byte, rx_byte_nx;
   logic                rx_valid, rx_valid_nx;

   logic miso_s;
   logic phase_done;
   logic ready;
   logic accept;

   spi_sync2 u_miso_sync (
      .clk (clk),
      .rst (rst),
      .d   (i_spi_miso),
      .q   (miso_s)
   );

   assign phase_done = (phase_cnt == PHASE_END);
   assign ready      = ((state == ST_IDLE) || (state == ST_WAIT)) && !rst;
   assign accept     = i_tx_valid && ready;

   // Next-state and next-output logic for the whole transfer sequencer.
   always_comb begin
      state_nx     = state;
      phase_cnt_nx = phase_cnt;
      bit_cnt_nx   = bit_cnt;
      tx_sr_nx     = tx_sr;
      rx_sr_nx     = rx_sr;
      last_nx      = last_q;
      sclk_nx      = sclk;
      cs_n_nx      = cs_n;
      mosi_nx      = mosi;
      rx_byte_nx   = rx_byte;
      rx_valid_nx  = 1'b0;

      unique case (state)
         ST_IDLE, ST_WAIT: begin
            if (accept) begin
               tx_sr_nx     = i_tx_byte;
               last_nx      = i_tx_last;
               cs_n_nx      = 1'b0;
               mosi_nx      = i_tx_byte[7];
               bit_cnt_nx   = '0;
               phase_cnt_nx = '0;
               state_nx     = ST_SETUP;
            end
         end

         // SETUP and LOW both end with a rising SCLK edge, where MISO is sampled.
         ST_SETUP, ST_LOW: begin
            if (phase_done) begin
               sclk_nx      = 1'b1;
               rx_sr_nx     = {rx_sr[SPI_BITS-2:0], miso_s};
               bit_cnt_nx   = bit_cnt + 4'd1;
               phase_cnt_nx = '0;
               state_nx     = ST_HIGH;
            end else begin
               phase_cnt_nx = phase_cnt + 8'd1;
            end
         end

         ST_HIGH: begin
            if (phase_done) begin
               sclk_nx      = 1'b0;
               phase_cnt_nx = '0;
               if (bit_cnt == BITS_DONE) begin
                  state_nx = ST_BYTE_END;
               end else begin
                  tx_sr_nx = {tx_sr[SPI_BITS-2:0], 1'b0};
                  mosi_nx  = tx_sr[SPI_BITS-2];
                  state_nx = ST_LOW;
               end
            end else begin
               phase_cnt_nx = phase_cnt + 8'd1;
            end
         end

         ST_BYTE_END: begin
            rx_byte_nx   = rx_sr;
            rx_valid_nx  = 1'b1;
            phase_cnt_nx = '0;
            state_nx     = last_q ? ST_HOLD : ST_WAIT;
         end

         ST_HOLD: begin
            if (phase_done) begin
               cs_n_nx      = 1'b1;
               phase_cnt_nx = '0;
               state_nx     = ST_GAP;
            end else begin
               phase_cnt_nx = phase_cnt + 8'd1;
            end
         end

         ST_GAP: begin
            if (phase_done) begin
               mosi_nx      = 1'b0;
               phase_cnt_nx = '0;
               state_nx     = ST_IDLE;
            end else begin
               phase_cnt_nx = phase_cnt + 8'd1;
            end
         end

         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         phase_cnt <= '0;
         bit_cnt   <= '0;
         tx_sr     <= '0;
         rx_sr     <= '0;
         last_q    <= 1'b0;
         sclk      <= 1'b0;
         cs_n      <= 1'b1;
         mosi      <= 1'b0;
         rx_byte   <= '0;
         rx_valid  <= 1'b0;
      end else begin
         state     <= state_nx;
         phase_cnt <= phase_cnt_nx;
         bit_cnt   <= bit_cnt_nx;
         tx_sr     <= tx_sr_nx;
         rx_sr     <= rx_sr_nx;
         last_q    <= last_nx;
         sclk      <= sclk_nx;
         cs_n      <= cs_n_nx;
         mosi      <= mosi_nx;
         rx_byte   <= rx_byte_nx;
         rx_valid  <= rx_valid_nx;
      end
   end

   assign o_tx_ready = ready;
   assign o_rx_byte  = rx_byte;
   assign o_rx_valid = rx_valid;
   assign o_busy     = (state != ST_IDLE);
   assign o_spi_clk  = sclk;
   assign o_spi_cs_n = cs_n;
   assign o_spi_mosi = mosi;

endmodule

// File: tb/tb_simple_spi_master.sv
// Self-checking bench for simple_spi_master with a behavioural SPI slave.
module tb_simple_spi_master;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_byte = '0;
   logic       tx_last = 1'b0;
   logic       tx_valid = 1'b0;
   logic       o_tx_ready;
   logic [7:0] o_rx_byte;
   logic       o_rx_valid;
   logic       o_busy;
   logic       o_spi_clk;
   logic       o_spi_cs_n;
   logic       o_spi_mosi;
   logic       spi_miso;

   int checks = 0;
   int errors = 0;

   logic       loopback = 1'b1;
   logic [7:0] slave_byte = '0;
   logic       slave_miso = 1'b0;
   int         sidx = 7;

   int   tick = 0;
   logic sclk_prev = 1'b0;
   logic cs_prev = 1'b1;
   int   acc_t = 0;

   logic       mosi_q[$];
   logic       exp_mosi[$];
   int         rise_t[$];
   int         fall_t[$];
   int         rx_t[$];
   int         csr_t[$];
   logic [7:0] rx_q[$];

   assign spi_miso = loopback ? o_spi_mosi : slave_miso;

   simple_spi_master #(.CLK_DIV(D)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_tx_byte  (tx_byte),
      .i_tx_last  (tx_last),
      .i_tx_valid (tx_valid),
      .o_tx_ready (o_tx_ready),
      .o_rx_byte  (o_rx_byte),
      .o_rx_valid (o_rx_valid),
      .o_busy     (o_busy),
      .o_spi_clk  (o_spi_clk),
      .o_spi_cs_n (o_spi_cs_n),
      .o_spi_mosi (o_spi_mosi),
      .i_spi_miso (spi_miso)
   );

   always #5 clk = ~clk;

   // Bus monitor and mode-0 slave model: slave shifts out MSB first,
   // presents bit 7 when CS_N falls and the next bit after each SCLK fall.
   always @(negedge clk) begin
      tick = tick + 1;
      if (o_spi_clk && !sclk_prev) begin
         rise_t.push_back(tick);
         mosi_q.push_back(o_spi_mosi);
      end
      if (!o_spi_clk && sclk_prev) begin
         fall_t.push_back(tick);
         sidx = (sidx == 0) ? 7 : sidx - 1;
         slave_miso = slave_byte[sidx];
      end
      if (!o_spi_cs_n && cs_prev) begin
         sidx = 7;
         slave_miso = slave_byte[7];
      end
      if (o_spi_cs_n && !cs_prev) csr_t.push_back(tick);
      if (o_rx_valid) begin
         rx_q.push_back(o_rx_byte);
         rx_t.push_back(tick);
      end
      sclk_prev = o_spi_clk;
      cs_prev   = o_spi_cs_n;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic clear_log();
      mosi_q.delete();
      exp_mosi.delete();
      rise_t.delete();
      fall_t.delete();
      rx_t.delete();
      csr_t.delete();
      rx_q.delete();
   endtask

   task automatic expect_bits(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) exp_mosi.push_back(b[i]);
   endtask

   // Index of the first MOSI bit that differs from the expected stream, -1 if none.
   function automatic int mosi_diff();
      if (mosi_q.size() != exp_mosi.size()) return 0;
      for (int i = 0; i < mosi_q.size(); i++)
         if (mosi_q[i] !== exp_mosi[i]) return i;
      return -1;
   endfunction

   task automatic send(input logic [7:0] b, input logic last, input bit hold_valid);
      int t;
      @(negedge clk); #2;
      tx_byte  = b;
      tx_last  = last;
      tx_valid = 1'b1;
      expect_bits(b);
      t = 0;
      while (!o_tx_ready && t < 1000) begin
         @(negedge clk); #2;
         t++;
      end
      if (!o_tx_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: ready=%0b required=1", o_tx_ready);
      end
      acc_t = tick + 1;
      @(posedge clk); #1;
      if (!hold_valid) tx_valid = 1'b0;
   endtask

   task automatic wait_idle(input int n_rx);
      int t;
      t = 0;
      while ((o_busy || rx_q.size() < n_rx) && t < 5000) begin
         @(negedge clk); #2;
         t++;
      end
      if (o_busy || rx_q.size() < n_rx) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: busy=%0b rx_count=%0d required busy=0 rx_count=%0d",
                  o_busy, rx_q.size(), n_rx);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tx_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      checks++;
      if ({o_spi_clk, o_spi_cs_n, o_spi_mosi, o_rx_valid, o_busy, o_tx_ready} !== 6'b010000) begin
         errors++;
         $display("FAIL reset_outputs: sclk,cs_n,mosi,rx_valid,busy,ready=%b required=010000",
                  {o_spi_clk, o_spi_cs_n, o_spi_mosi, o_rx_valid, o_busy, o_tx_ready});
      end
      checks++;
      if (o_rx_byte !== 8'h00) begin
         errors++;
         $display("FAIL reset_rx_byte: got=%h required=00", o_rx_byte);
      end
      tx_valid = 1'b1;
      @(negedge clk); #2;
      checks++;
      if (o_tx_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_in_reset: got=%b required=0", o_tx_ready);
      end
      rst = 1'b0;
      tx_valid = 1'b0;
      @(negedge clk); #2;
      checks++;
      if (o_tx_ready !== 1'b1 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL ready_after_reset: ready=%b busy=%b required ready=1 busy=0",
                  o_tx_ready, o_busy);
      end
   endtask

   task automatic test_loopback();
      bit bad;
      clear_log();
      loopback = 1'b1;
      send(8'hA5, 1'b1, 1'b0);
      wait_idle(1);
      checks++;
      if (mosi_diff() != -1) begin
         errors++;
         $display("FAIL loop_mosi: rises=%0d first_bad=%0d required 8 bits of a5", mosi_q.size(), mosi_diff());
      end
      checks++;
      if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
         errors++;
         $display("FAIL loop_rx: count=%0d byte=%h required count=1 byte=a5",
                  rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
      end
      if (rise_t.size() == 8 && fall_t.size() == 8 && rx_t.size() == 1 && csr_t.size() == 1) begin
         checks++;
         if (rise_t[0] - acc_t != D) begin
            errors++;
            $display("FAIL loop_first_rise: got=%0d required=%0d", rise_t[0] - acc_t, D);
         end
         checks++;
         if (rx_t[0] - acc_t != 16 * D + 1) begin
            errors++;
            $display("FAIL loop_rx_latency: got=%0d required=%0d", rx_t[0] - acc_t, 16 * D + 1);
         end
         checks++;
         if (csr_t[0] - rx_t[0] != D) begin
            errors++;
            $display("FAIL loop_cs_rise: got=%0d required=%0d", csr_t[0] - rx_t[0], D);
         end
         bad = 0;
         for (int i = 0; i < 8; i++) begin
            if (fall_t[i] - rise_t[i] != D) bad = 1;
            if (i < 7 && rise_t[i + 1] - rise_t[i] != 2 * D) bad = 1;
         end
         checks++;
         if (bad) begin
            errors++;
            $display("FAIL loop_sclk_phases: high=%0d period=%0d required high=%0d period=%0d",
                     fall_t[0] - rise_t[0], rise_t[1] - rise_t[0], D, 2 * D);
         end
      end else begin
         checks++;
         errors++;
         $display("FAIL loop_edge_count: rises=%0d falls=%0d rx=%0d cs_rises=%0d required 8,8,1,1",
                  rise_t.size(), fall_t.size(), rx_t.size(), csr_t.size());
      end
   endtask

   task automatic test_back_to_back();
      clear_log();
      loopback = 1'b1;
      send(8'h3C, 1'b0, 1'b1);
      send(8'hC3, 1'b1, 1'b0);
      wait_idle(2);
      checks++;
      if (rx_q.size() != 2 || rx_q[0] !== 8'h3C || rx_q[1] !== 8'hC3) begin
         errors++;
         $display("FAIL b2b_rx: count=%0d first=%h second=%h required 3c then c3", rx_q.size(),
                  (rx_q.size() > 0) ? rx_q[0] : 8'hxx, (rx_q.size() > 1) ? rx_q[1] : 8'hxx);
      end
      checks++;
      if (rise_t.size() != 16 || mosi_diff() != -1) begin
         errors++;
         $display("FAIL b2b_mosi: rises=%0d first_bad=%0d required 16 rises matching", rise_t.size(), mosi_diff());
      end
      checks++;
      if (csr_t.size() != 1 || rx_t.size() != 2 || (csr_t.size() == 1 && rx_t.size() == 2 && csr_t[0] < rx_t[1])) begin
         errors++;
         $display("FAIL b2b_cs_low: cs_rises=%0d required exactly 1 after the last byte", csr_t.size());
      end
      if (rise_t.size() == 16) begin
         checks++;
         if (rise_t[8] - rise_t[7] != 2 * D + 2) begin
            errors++;
            $display("FAIL b2b_gap: got=%0d required=%0d", rise_t[8] - rise_t[7], 2 * D + 2);
         end
      end
   endtask

   task automatic test_stall();
      logic [7:0] b1, b2;
      int t;
      clear_log();
      loopback   = 1'b0;
      slave_byte = 8'($urandom);
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      send(b1, 1'b0, 1'b0);
      t = 0;
      while (rx_q.size() < 1 && t < 1000) begin
         @(negedge clk); #2;
         t++;
      end
      for (int i = 0; i < 50; i++) begin
         @(negedge clk); #2;
         checks++;
         if (o_spi_clk !== 1'b0 || o_spi_cs_n !== 1'b0 || o_tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: cycle=%0d sclk=%b cs_n=%b ready=%b required 0,0,1",
                     i, o_spi_clk, o_spi_cs_n, o_tx_ready);
         end
      end
      send(b2, 1'b1, 1'b0);
      wait_idle(2);
      checks++;
      if (rx_q.size() != 2 || rx_q[0] !== slave_byte || rx_q[1] !== slave_byte) begin
         errors++;
         $display("FAIL stall_rx: count=%0d first=%h second=%h required %h twice", rx_q.size(),
                  (rx_q.size() > 0) ? rx_q[0] : 8'hxx, (rx_q.size() > 1) ? rx_q[1] : 8'hxx, slave_byte);
      end
      checks++;
      if (mosi_diff() != -1 || csr_t.size() != 1) begin
         errors++;
         $display("FAIL stall_mosi: first_bad=%0d cs_rises=%0d required -1 and 1", mosi_diff(), csr_t.size());
      end
   endtask

   task automatic test_random_frames();
      int n;
      for (int f = 0; f < 5; f++) begin
         clear_log();
         loopback   = 1'b0;
         slave_byte = 8'($urandom);
         n = $urandom_range(1, 3);
         for (int k = 0; k < n; k++)
            send(8'($urandom), (k == n - 1), (k != n - 1) && ($urandom_range(0, 1) == 1));
         wait_idle(n);
         checks++;
         if (mosi_diff() != -1 || rise_t.size() != 8 * n || csr_t.size() != 1) begin
            errors++;
            $display("FAIL rand_frame%0d_mosi: rises=%0d first_bad=%0d cs_rises=%0d required %0d,-1,1",
                     f, rise_t.size(), mosi_diff(), csr_t.size(), 8 * n);
         end
         for (int k = 0; k < n; k++) begin
            checks++;
            if (k >= rx_q.size() || rx_q[k] !== slave_byte) begin
               errors++;
               $display("FAIL rand_frame%0d_rx%0d: got=%h required=%h", f, k,
                        (k < rx_q.size()) ? rx_q[k] : 8'hxx, slave_byte);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int t;
      clear_log();
      loopback   = 1'b0;
      slave_byte = 8'($urandom);
      send(8'($urandom), 1'b1, 1'b0);
      t = 0;
      while (rise_t.size() < 4 && t < 1000) begin
         @(negedge clk); #2;
         t++;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (o_spi_cs_n !== 1'b1 || o_spi_clk !== 1'b0 || o_rx_valid !== 1'b0 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL midreset_outputs: cs_n=%b sclk=%b rx_valid=%b busy=%b required 1,0,0,0",
                  o_spi_cs_n, o_spi_clk, o_rx_valid, o_busy);
      end
      @(negedge clk); #2;
      rst = 1'b0;
      repeat (4 * D) @(negedge clk);
      #2;
      checks++;
      if (rx_q.size() != 0 || o_rx_byte !== 8'h00) begin
         errors++;
         $display("FAIL midreset_no_rx: count=%0d byte=%h required count=0 byte=00", rx_q.size(), o_rx_byte);
      end
      clear_log();
      loopback = 1'b1;
      send(8'hFF, 1'b1, 1'b0);
      wait_idle(1);
      checks++;
      if (rx_q.size() != 1 || rx_q[0] !== 8'hFF) begin
         errors++;
         $display("FAIL midreset_next: count=%0d byte=%h required count=1 byte=ff",
                  rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
      end
   endtask

   task automatic test_ignored();
      logic [7:0] b;
      int t;
      clear_log();
      loopback = 1'b1;
      b = 8'($urandom);
      send(b, 1'b1, 1'b0);
      t = 0;
      while (!o_spi_clk && t < 1000) begin
         @(negedge clk); #2;
         t++;
      end
      tx_byte  = ~b;
      tx_last  = 1'b0;
      tx_valid = 1'b1;
      checks++;
      if (o_tx_ready !== 1'b0) begin
         errors++;
         $display("FAIL ignored_ready: got=%b required=0", o_tx_ready);
      end
      @(negedge clk); #2;
      tx_valid = 1'b0;
      wait_idle(1);
      repeat (3 * D) @(negedge clk);
      #2;
      checks++;
      if (rx_q.size() != 1 || rx_q[0] !== b || rise_t.size() != 8 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL ignored_count: rx=%0d byte=%h rises=%0d busy=%b required 1,%h,8,0",
                  rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx, rise_t.size(), o_busy, b);
      end
      checks++;
      if (mosi_diff() != -1) begin
         errors++;
         $display("FAIL ignored_mosi: first_bad=%0d required -1", mosi_diff());
      end
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_back_to_back();
      test_stall();
      test_random_frames();
      test_reset_mid();
      test_ignored();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
